vga_timing_gen: RTL and testbench

Parametrised VGA timing generator and pixel-output stage, successor to the fixed 640x480 controller. Timing geometry, sync polarity, colour-channel widths and pixel-source latency are all configurable. A built-in test-pattern source (colour bars, checkerboard, solid colour) can be selected per frame in place of the external pixel source. It sits between the PLL-derived pixel clock and the picture generator, and drives the hsync, vsync and rgb pins.

---
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: configurable VGA timing generator with latency-matched pixel pipeline and test patterns
module vga_timing_gen #(
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int H_VALID   = 640,
    parameter int H_FRONT   = 16,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_VALID   = 480,
    parameter int V_FRONT   = 10,
    parameter bit SYNC_POL  = 1'b0,
    parameter int R_W       = 5,
    parameter int G_W       = 6,
    parameter int B_W       = 5,
    parameter int PIX_LAT   = 0,
    parameter int CHK_SHIFT = 5,
    localparam int RGB_W    = R_W + G_W + B_W
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic [1:0]       mode,
    input  logic [RGB_W-1:0] solid_color,
    input  logic [RGB_W-1:0] pix_data,
    output logic             pix_req,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             frame_start,
    output logic [15:0]      frame_cnt
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int VA      = V_SYNC + V_BACK;
    localparam int BAR_W   = H_VALID / 8;
    // {R,G,B} on/off per bar, bar 0 in the low bits: white..black
    localparam logic [23:0] BARS = 24'b000_001_100_101_010_011_110_111;

    typedef struct packed {
        logic       first;
        logic       hs;
        logic       vs;
        logic       act;
        logic [9:0] x;
        logic [9:0] y;
    } tap_t;

    logic [11:0]      h_cnt, v_cnt;
    logic [1:0]       mode_r;
    logic             started;
    logic             h_last, v_last;
    tap_t             dl [PIX_LAT+1];
    tap_t             nxt, o;
    logic [9:0]       bar;
    logic [2:0]       bar_c;
    logic [RGB_W-1:0] pix;

    assign pix_req = dl[0].act;
    assign pix_x   = dl[0].x;
    assign pix_y   = dl[0].y;

    always_comb begin
        h_last    = h_cnt == 12'(H_TOTAL - 1);
        v_last    = v_cnt == 12'(V_TOTAL - 1);
        nxt.first = h_cnt == 12'd0 && v_cnt == 12'd0;
        nxt.hs    = h_cnt < 12'(H_SYNC);
        nxt.vs    = v_cnt < 12'(V_SYNC);
        nxt.act   = h_cnt >= 12'(HA) && h_cnt < 12'(HA + H_VALID) &&
                    v_cnt >= 12'(VA) && v_cnt < 12'(VA + V_VALID);
        nxt.x     = nxt.act ? 10'(h_cnt - 12'(HA)) : 10'd0;
        nxt.y     = nxt.act ? 10'(v_cnt - 12'(VA)) : 10'd0;
        o         = dl[PIX_LAT];
        bar       = o.x / 10'(BAR_W);
        // the division remainder falls into the last (black) bar
        bar_c     = BARS[5'(bar > 10'd7 ? 10'd7 : bar) * 5'd3 +: 3];
        pix       = mode_r == 2'd0 ? pix_data :
                    mode_r == 2'd1 ? {{R_W{bar_c[2]}}, {G_W{bar_c[1]}}, {B_W{bar_c[0]}}} :
                    mode_r == 2'd2 ? {RGB_W{o.x[CHK_SHIFT] ^ o.y[CHK_SHIFT]}} : solid_color;
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            mode_r      <= '0;
            started     <= 1'b0;
            for (int i = 0; i <= PIX_LAT; i++) dl[i] <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            vga_rgb     <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
            if (h_last) v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
            if (nxt.first) mode_r <= mode;
            dl[0] <= nxt;
            for (int i = 1; i <= PIX_LAT; i++) dl[i] <= dl[i-1];
            hsync       <= o.hs ? SYNC_POL : ~SYNC_POL;
            vsync       <= o.vs ? SYNC_POL : ~SYNC_POL;
            de          <= o.act;
            vga_rgb     <= o.act ? pix : '0;
            frame_start <= o.first;
            // the first frame after reset has not completed a frame yet
            if (o.first) started <= 1'b1;
            if (o.first && started) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of timing geometry, patterns, mode switching, latency and reset
module tb_vga_timing_gen;
    localparam int HT = 29, VT = 14, FRAME = HT * VT, HA = 7, VA = 4;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] solid;
        int          x;
        int          y;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [1:0]  mode_a = 2'd0, mode_b = 2'd0;
    logic [15:0] solid_a = 16'd0, solid_b = 16'd0;
    logic [15:0] pd_a, pd_b, p1, p2, p3;
    logic        pix_req_a, hsync_a, vsync_a, de_a, frame_start_a;
    logic        pix_req_b, hsync_b, vsync_b, de_b, frame_start_b;
    logic [9:0]  pix_x_a, pix_y_a, pix_x_b, pix_y_b;
    logic [15:0] vga_rgb_a, vga_rgb_b, frame_cnt_a, frame_cnt_b;

    logic        sel = 1'b0;
    logic        m_hs, m_vs, m_de, m_fs, m_req;
    logic [15:0] m_rgb, m_fc;

    int          errors = 0, checks = 0;
    int          hs_act, vs_act, de_n, req_n, blank_bad, fs_extra, first_de;
    logic        fs_next;
    logic [15:0] fc_start, fc_next;
    logic [15:0] fb [8][20];

    always #5 clk = ~clk;

    vga_timing_gen #(.H_SYNC(4), .H_BACK(3), .H_VALID(20), .H_FRONT(2), .V_SYNC(2), .V_BACK(2),
                     .V_VALID(8), .V_FRONT(2), .CHK_SHIFT(2)) dut_a (
        .vga_clk(clk), .sys_rst(sys_rst), .mode(mode_a), .solid_color(solid_a), .pix_data(pd_a),
        .pix_req(pix_req_a), .pix_x(pix_x_a), .pix_y(pix_y_a), .hsync(hsync_a), .vsync(vsync_a),
        .de(de_a), .vga_rgb(vga_rgb_a), .frame_start(frame_start_a), .frame_cnt(frame_cnt_a));

    vga_timing_gen #(.H_SYNC(4), .H_BACK(3), .H_VALID(20), .H_FRONT(2), .V_SYNC(2), .V_BACK(2),
                     .V_VALID(8), .V_FRONT(2), .SYNC_POL(1'b1), .PIX_LAT(3)) dut_b (
        .vga_clk(clk), .sys_rst(sys_rst), .mode(mode_b), .solid_color(solid_b), .pix_data(pd_b),
        .pix_req(pix_req_b), .pix_x(pix_x_b), .pix_y(pix_y_b), .hsync(hsync_b), .vsync(vsync_b),
        .de(de_b), .vga_rgb(vga_rgb_b), .frame_start(frame_start_b), .frame_cnt(frame_cnt_b));

    assign pd_a = {pix_x_a[4:0], pix_y_a[5:0], pix_x_a[4:0]};
    always @(posedge clk) begin
        p1 <= {pix_x_b[4:0], pix_y_b[5:0], 5'd0};
        p2 <= p1;
        p3 <= p2;
    end
    assign pd_b = p3;

    assign m_hs  = sel ? hsync_b : ~hsync_a;
    assign m_vs  = sel ? vsync_b : ~vsync_a;
    assign m_de  = sel ? de_b : de_a;
    assign m_fs  = sel ? frame_start_b : frame_start_a;
    assign m_req = sel ? pix_req_b : pix_req_a;
    assign m_rgb = sel ? vga_rgb_b : vga_rgb_a;
    assign m_fc  = sel ? frame_cnt_b : frame_cnt_a;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (m_fs) return;
        end
        chk("fs_timeout", 0, 1);
    endtask

    task automatic capture(input int chg_at, input logic [1:0] chg_mode);
        int   ox, oy;
        logic pde;
        hs_act = 0; vs_act = 0; de_n = 0; req_n = 0; blank_bad = 0; fs_extra = 0; first_de = -1;
        ox = 0; oy = 0; pde = 1'b0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 20; x++) fb[y][x] = 16'hDEAD;
        wait_fs();
        fc_start = m_fc;
        for (int n = 0; n < FRAME; n++) begin
            if (n > 0) @(negedge clk);
            if (n == chg_at) mode_a = chg_mode;
            if (n > 0 && m_fs) fs_extra++;
            hs_act += int'(m_hs);
            vs_act += int'(m_vs);
            req_n  += int'(m_req);
            if (m_de) begin
                if (first_de < 0) first_de = n;
                if (oy < 8 && ox < 20) fb[oy][ox] = m_rgb;
                de_n++;
                ox++;
                pde = 1'b1;
            end else begin
                if (m_rgb != 16'd0) blank_bad++;
                if (pde) begin
                    oy++;
                    ox = 0;
                end
                pde = 1'b0;
            end
        end
        @(negedge clk);
        fs_next = m_fs;
        fc_next = m_fc;
    endtask

    function automatic int ext_bad(input bit b);
        int          bad;
        logic [15:0] e;
        bad = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 20; x++) begin
                e = b ? {5'(x), 6'(y), 5'd0} : {5'(x), 6'(y), 5'(x)};
                if (fb[y][x] !== e) bad++;
            end
        return bad;
    endfunction

    function automatic int count_ne(input logic [15:0] v);
        int bad;
        bad = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 20; x++) if (fb[y][x] !== v) bad++;
        return bad;
    endfunction

    initial begin
        vec_t vt [19];
        int   cur, k, de_early, rst_bad;
        vt[0]  = '{2'd0, 16'h0000, 0, 0, 16'h0000};
        vt[1]  = '{2'd0, 16'h0000, 19, 7, 16'h98F3};
        vt[2]  = '{2'd0, 16'h0000, 5, 3, 16'h2865};
        vt[3]  = '{2'd1, 16'h0000, 0, 0, 16'hFFFF};
        vt[4]  = '{2'd1, 16'h0000, 1, 3, 16'hFFFF};
        vt[5]  = '{2'd1, 16'h0000, 2, 0, 16'hFFE0};
        vt[6]  = '{2'd1, 16'h0000, 4, 1, 16'h07FF};
        vt[7]  = '{2'd1, 16'h0000, 6, 2, 16'h07E0};
        vt[8]  = '{2'd1, 16'h0000, 8, 0, 16'hF81F};
        vt[9]  = '{2'd1, 16'h0000, 10, 0, 16'hF800};
        vt[10] = '{2'd1, 16'h0000, 12, 5, 16'h001F};
        vt[11] = '{2'd1, 16'h0000, 14, 0, 16'h0000};
        vt[12] = '{2'd1, 16'h0000, 19, 7, 16'h0000};
        vt[13] = '{2'd2, 16'h0000, 0, 0, 16'h0000};
        vt[14] = '{2'd2, 16'h0000, 4, 0, 16'hFFFF};
        vt[15] = '{2'd2, 16'h0000, 4, 4, 16'h0000};
        vt[16] = '{2'd2, 16'h0000, 0, 4, 16'hFFFF};
        vt[17] = '{2'd3, 16'hF800, 0, 0, 16'hF800};
        vt[18] = '{2'd3, 16'hF800, 19, 7, 16'hF800};

        repeat (3) @(negedge clk);
        chk("rst_pix_req", int'(pix_req_a), 0);
        chk("rst_pix_x", int'(pix_x_a), 0);
        chk("rst_de", int'(de_a), 0);
        chk("rst_rgb", int'(vga_rgb_a), 0);
        chk("rst_hsync_lo_pol", int'(hsync_a), 1);
        chk("rst_vsync_lo_pol", int'(vsync_a), 1);
        chk("rst_hsync_hi_pol", int'(hsync_b), 0);
        chk("rst_frame_cnt", int'(frame_cnt_a), 0);
        chk("rst_frame_start", int'(frame_start_a), 0);
        sys_rst = 1'b0;

        sel = 1'b0;
        capture(-1, 2'd0);
        chk("a_frame_period", int'(fs_next), 1);
        chk("a_hsync_active", hs_act, 4 * VT);
        chk("a_vsync_active", vs_act, 2 * HT);
        chk("a_de_cycles", de_n, 160);
        chk("a_req_cycles", req_n, 160);
        chk("a_first_de", first_de, VA * HT + HA);
        chk("a_blank_zero", blank_bad, 0);
        chk("a_single_fs", fs_extra, 0);
        chk("a_frame_cnt_inc", int'(fc_next - fc_start), 1);
        chk("a_ext_pixels", ext_bad(1'b0), 0);
        cur = 0;

        for (int i = 0; i < 19; i++) begin
            if (int'(vt[i].mode) != cur) begin
                mode_a  = vt[i].mode;
                solid_a = vt[i].solid;
                wait_fs();
                capture(-1, vt[i].mode);
                cur = int'(vt[i].mode);
                chk($sformatf("blank_zero_mode%0d", cur), blank_bad, 0);
            end
            chk($sformatf("vec%0d", i), int'(fb[vt[i].y][vt[i].x]), int'(vt[i].exp));
        end

        mode_a  = 2'd0;
        solid_a = 16'hF800;
        capture(6 * HT + 10, 2'd3);
        chk("switch_old_frame_ext", ext_bad(1'b0), 0);
        capture(-1, 2'd3);
        chk("switch_new_frame_solid", count_ne(16'hF800), 0);

        sel = 1'b1;
        capture(-1, 2'd3);
        chk("b_frame_period", int'(fs_next), 1);
        chk("b_hsync_active", hs_act, 4 * VT);
        chk("b_vsync_active", vs_act, 2 * HT);
        chk("b_de_cycles", de_n, 160);
        chk("b_first_de", first_de, VA * HT + HA);
        chk("b_line7_first_pix", int'(fb[7][0]), 16'h00E0);
        chk("b_ext_pixels", ext_bad(1'b1), 0);

        wait_fs();
        repeat (160) @(negedge clk);
        sys_rst = 1'b1;
        rst_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (hsync_b !== 1'b0 || vsync_b !== 1'b0 || de_b !== 1'b0 ||
                frame_cnt_b !== 16'd0 || vga_rgb_b !== 16'd0) rst_bad++;
        end
        chk("b_reset_outputs", rst_bad, 0);
        sys_rst  = 1'b0;
        k        = 0;
        de_early = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (de_b) de_early++;
            if (frame_start_b) begin
                k = i;
                break;
            end
        end
        chk("b_restart_latency", k, 5);
        chk("b_no_partial_de", de_early, 0);
        chk("b_restart_frame_cnt", int'(frame_cnt_b), 0);
        capture(-1, 2'd3);
        chk("b_frame_cnt_first_inc", int'(fc_start), 1);
        chk("b_restart_first_de", first_de, VA * HT + HA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
